// File: rtl/servile_rf_serdes.sv
// Bit-serial RF front end: packs the core's 1-bit write stream into byte writes and
// unpacks byte reads back into a gapless 1-bit read stream (1-cycle SRAM read latency).
module servile_rf_serdes #(
   parameter int unsigned rf_regs  = 32,
   parameter int unsigned rf_depth = $clog2(rf_regs * 4),
   parameter int unsigned rw       = $clog2(rf_regs)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_wen,
   input  logic [rw-1:0]       i_wreg,
   input  logic                i_wdata,
   input  logic                i_rreq,
   input  logic [rw-1:0]       i_rreg,
   output logic                o_rbusy,
   output logic                o_rvalid,
   output logic                o_rdata,
   output logic [rf_depth-1:0] o_waddr,
   output logic [7:0]          o_wdata,
   output logic                o_wen,
   output logic [rf_depth-1:0] o_raddr,
   output logic                o_ren,
   input  logic [7:0]          i_rdata
);

   // ---------------------------------------------------------------- write path
   logic [4:0]          r_wcnt;
   logic [7:0]          r_wshift;
   logic [rw-1:0]       r_wreg;
   logic                r_wen;
   logic [rf_depth-1:0] r_waddr;
   logic [7:0]          r_wdata;
   logic [7:0]          w_wbyte;
   logic                w_wbyte_done;

   assign w_wbyte      = {i_wdata, r_wshift[7:1]};
   assign w_wbyte_done = i_wen && (r_wcnt[2:0] == 3'd7);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wcnt   <= '0;
         r_wshift <= '0;
         r_wreg   <= '0;
         r_wen    <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
      end else begin
         r_wen <= w_wbyte_done;
         if (w_wbyte_done) begin
            r_waddr <= {r_wreg, r_wcnt[4:3]};
            r_wdata <= w_wbyte;
         end
         if (i_wen) begin
            r_wshift <= w_wbyte;
            r_wcnt   <= r_wcnt + 5'd1;
            if (r_wcnt == 5'd0) r_wreg <= i_wreg;
         end else begin
            // Dropping i_wen mid-register discards any partial byte.
            r_wcnt <= '0;
         end
      end
   end

   assign o_wen   = r_wen;
   assign o_waddr = r_waddr;
   assign o_wdata = r_wdata;

   // ----------------------------------------------------------------- read path
   // StAddr issues the first byte read; StFetch waits for its data to return.
   typedef enum logic [1:0] {StIdle, StAddr, StFetch, StStream} rd_state_e;

   rd_state_e     r_state, w_state_nxt;
   logic [rw-1:0] r_rreg;
   logic [4:0]    r_rcnt;
   logic [7:0]    r_rshift;
   logic          w_prefetch;
   logic          w_reload;

   assign w_prefetch = (r_state == StStream) && (r_rcnt[2:0] == 3'd6) && (r_rcnt[4:3] != 2'd3);
   assign w_reload   = (r_rcnt[2:0] == 3'd7) && (r_rcnt[4:3] != 2'd3);

   always_comb begin
      w_state_nxt = r_state;
      o_rbusy     = 1'b1;
      o_rvalid    = 1'b0;
      o_rdata     = 1'b0;
      o_ren       = 1'b0;
      o_raddr     = '0;
      unique case (r_state)
         StIdle: begin
            o_rbusy = 1'b0;
            if (i_rreq) w_state_nxt = StAddr;
         end
         StAddr: begin
            o_ren       = 1'b1;
            o_raddr     = {r_rreg, 2'b00};
            w_state_nxt = StFetch;
         end
         StFetch: w_state_nxt = StStream;
         StStream: begin
            o_rvalid = 1'b1;
            o_rdata  = r_rshift[0];
            if (w_prefetch) begin
               o_ren   = 1'b1;
               o_raddr = {r_rreg, 2'(r_rcnt[4:3] + 2'd1)};
            end
            if (r_rcnt == 5'd31) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_rreg   <= '0;
         r_rcnt   <= '0;
         r_rshift <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            StIdle: if (i_rreq) r_rreg <= i_rreg;
            StFetch: begin
               r_rshift <= i_rdata;
               r_rcnt   <= '0;
            end
            StStream: begin
               r_rcnt <= r_rcnt + 5'd1;
               // Prefetched byte lands exactly as the current byte's last bit leaves.
               if (w_reload) r_rshift <= i_rdata;
               else          r_rshift <= {1'b0, r_rshift[7:1]};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_servile_rf_serdes.sv
// Directed bench for servile_rf_serdes with a byte-wide SRAM model behind the RF port.
module tb_servile_rf_serdes;

   localparam int unsigned LogLen = 2048;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_wen, i_wdata, i_rreq;
   logic [4:0] i_wreg, i_rreg;
   logic       o_rbusy, o_rvalid, o_rdata, o_wen, o_ren;
   logic [6:0] o_waddr, o_raddr;
   logic [7:0] o_wdata;
   logic [7:0] r_sram_q;
   logic [7:0] mem [128];

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;

   logic       wen_log   [LogLen];
   logic [6:0] waddr_log [LogLen];
   logic [7:0] wdata_log [LogLen];
   logic       ren_log   [LogLen];
   logic [6:0] raddr_log [LogLen];
   logic       rv_log    [LogLen];
   logic       rd_log    [LogLen];
   logic       busy_log  [LogLen];

   always #5 clk = ~clk;

   servile_rf_serdes dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_wen    (i_wen),
      .i_wreg   (i_wreg),
      .i_wdata  (i_wdata),
      .i_rreq   (i_rreq),
      .i_rreg   (i_rreg),
      .o_rbusy  (o_rbusy),
      .o_rvalid (o_rvalid),
      .o_rdata  (o_rdata),
      .o_waddr  (o_waddr),
      .o_wdata  (o_wdata),
      .o_wen    (o_wen),
      .o_raddr  (o_raddr),
      .o_ren    (o_ren),
      .i_rdata  (r_sram_q)
   );

   // Read-first SRAM, data valid the cycle after o_ren.
   always @(posedge clk) begin
      if (o_wen) mem[o_waddr] <= o_wdata;
      if (o_ren) r_sram_q <= mem[o_raddr];
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < LogLen) begin
         wen_log[cyc]   = o_wen;
         waddr_log[cyc] = o_waddr;
         wdata_log[cyc] = o_wdata;
         ren_log[cyc]   = o_ren;
         raddr_log[cyc] = o_raddr;
         rv_log[cyc]    = o_rvalid;
         rd_log[cyc]    = o_rdata;
         busy_log[cyc]  = o_rbusy;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [4:0] rg, input logic [31:0] val, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         i_wen   = 1'b1;
         i_wreg  = rg;
         i_wdata = val[i];
         next_cycle();
      end
      i_wen   = 1'b0;
      i_wdata = 1'b0;
   endtask

   task automatic read_req(input logic [4:0] rg);
      i_rreq = 1'b1;
      i_rreg = rg;
      next_cycle();
      i_rreq = 1'b0;
   endtask

   task automatic check_writes(input string tag, input int c0, input logic [4:0] rg,
                               input logic [31:0] val);
      int cnt = 0;
      for (int i = c0 + 1; i <= c0 + 32; i++) cnt += int'(wen_log[i]);
      check_eq({tag, " wen count"}, cnt, 4);
      for (int b = 0; b < 4; b++) begin
         check_eq($sformatf("%s wen b%0d", tag, b), wen_log[c0 + 8 * (b + 1)], 1'b1);
         check_eq($sformatf("%s waddr b%0d", tag, b), waddr_log[c0 + 8 * (b + 1)],
                  32'(rg) * 4 + b);
         check_eq($sformatf("%s wdata b%0d", tag, b), wdata_log[c0 + 8 * (b + 1)],
                  32'(val[8 * b +: 8]));
      end
   endtask

   task automatic check_read(input string tag, input int t, input logic [4:0] rg,
                             input logic [31:0] val);
      int          nren = 0;
      int          nval = 0;
      logic [31:0] word = '0;
      for (int i = t; i <= t + 34; i++) nren += int'(ren_log[i]);
      for (int i = t; i <= t + 35; i++) nval += int'(rv_log[i]);
      check_eq({tag, " ren count"}, nren, 4);
      for (int b = 0; b < 4; b++) begin
         check_eq($sformatf("%s ren b%0d", tag, b), ren_log[t + 1 + 8 * b], 1'b1);
         check_eq($sformatf("%s raddr b%0d", tag, b), raddr_log[t + 1 + 8 * b],
                  32'(rg) * 4 + b);
      end
      check_eq({tag, " rvalid count"}, nval, 32);
      check_eq({tag, " rvalid T+2"}, rv_log[t + 2], 1'b0);
      check_eq({tag, " rvalid T+3"}, rv_log[t + 3], 1'b1);
      check_eq({tag, " rvalid T+34"}, rv_log[t + 34], 1'b1);
      check_eq({tag, " busy T"}, busy_log[t], 1'b0);
      check_eq({tag, " busy T+1"}, busy_log[t + 1], 1'b1);
      check_eq({tag, " busy T+34"}, busy_log[t + 34], 1'b1);
      check_eq({tag, " busy T+35"}, busy_log[t + 35], 1'b0);
      for (int i = 0; i < 32; i++) word[i] = rd_log[t + 3 + i];
      check_eq({tag, " data"}, word, val);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, " rbusy"}, o_rbusy, 1'b0);
      check_eq({tag, " rvalid"}, o_rvalid, 1'b0);
      check_eq({tag, " rdata"}, o_rdata, 1'b0);
      check_eq({tag, " wen"}, o_wen, 1'b0);
      check_eq({tag, " waddr"}, o_waddr, 7'd0);
      check_eq({tag, " wdata"}, o_wdata, 8'd0);
      check_eq({tag, " ren"}, o_ren, 1'b0);
      check_eq({tag, " raddr"}, o_raddr, 7'd0);
   endtask

   initial begin
      int          c0, c1, t, t2;
      logic [31:0] v5, v3, v7, v9;
      v5 = 32'hA5C3_1E78;
      v3 = 32'hDEAD_BEEF;
      v7 = 32'h0F1E_2D3C;
      v9 = 32'h3C5A_96E1;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      for (int i = 0; i < int'(LogLen); i++) begin
         wen_log[i] = 1'b0; ren_log[i] = 1'b0; rv_log[i] = 1'b0;
         rd_log[i] = 1'b0; busy_log[i] = 1'b0;
         waddr_log[i] = '0; wdata_log[i] = '0; raddr_log[i] = '0;
      end
      r_sram_q = 8'h00;
      rst_n   = 1'b0;
      i_wen   = 1'b0; i_wreg = '0; i_wdata = 1'b0;
      i_rreq  = 1'b0; i_rreg = '0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // Full register write, then read it back.
      c0 = int'(cyc);
      write_word(5'd5, v5, 32);
      repeat (3) next_cycle();
      check_writes("wr5", c0, 5'd5, v5);

      t = int'(cyc);
      read_req(5'd5);
      repeat (40) next_cycle();
      check_read("rd5", t, 5'd5, v5);

      // Aborted write after 12 bits, then a clean write of reg 3.
      c0 = int'(cyc);
      write_word(5'd2, 32'h1122_3344, 12);
      repeat (3) next_cycle();
      c1 = int'(cyc);
      write_word(5'd3, v3, 32);
      repeat (3) next_cycle();
      begin
         int cnt = 0;
         for (int i = c0; i < c1; i++) cnt += int'(wen_log[i]);
         check_eq("abort wen count", cnt, 1);
      end
      check_eq("abort wen", wen_log[c0 + 8], 1'b1);
      check_eq("abort waddr", waddr_log[c0 + 8], 7'h08);
      check_eq("abort wdata", wdata_log[c0 + 8], 8'h44);
      check_writes("wr3", c1, 5'd3, v3);

      // Request during an active read is ignored; the first idle cycle accepts one.
      t = int'(cyc);
      read_req(5'd5);
      repeat (9) next_cycle();
      read_req(5'd2);
      repeat (24) next_cycle();
      t2 = int'(cyc);
      check_eq("reissue at T+35", t2, t + 35);
      read_req(5'd3);
      repeat (40) next_cycle();
      check_read("rd5 busy", t, 5'd5, v5);
      check_read("rd3 b2b", t2, 5'd3, v3);

      // Back-to-back writes of reg 9 then 7, reading reg 9 while reg 7 is written.
      c0 = int'(cyc);
      t  = c0 + 33;
      fork
         begin
            write_word(5'd9, v9, 32);
            write_word(5'd7, v7, 32);
         end
         begin
            repeat (33) next_cycle();
            read_req(5'd9);
         end
      join
      repeat (40) next_cycle();
      check_writes("wr9", c0, 5'd9, v9);
      check_writes("wr7", c0 + 32, 5'd7, v7);
      check_read("rd9 conc", t, 5'd9, v9);

      // Reset while bit 17 of a read is on the wire.
      t = int'(cyc);
      read_req(5'd7);
      repeat (19) next_cycle();
      check_eq("pre-reset rvalid", o_rvalid, 1'b1);
      check_eq("pre-reset bit17", o_rdata, v7[17]);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midread reset");
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      check_eq("post-reset busy", o_rbusy, 1'b0);
      t = int'(cyc);
      read_req(5'd7);
      repeat (40) next_cycle();
      check_read("rd7 after reset", t, 5'd7, v7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
